// File: rtl/mvu_inp_buf_pkg.sv
// Shared definitions for the MVU input-activation buffer: activation word
// geometry, buffer FSM state type and a counter-width helper.
package mvau_defn;

    localparam int unsigned SIMD  = 2;
    localparam int unsigned TSrcI = 4;
    localparam int unsigned TI    = SIMD * TSrcI;

    typedef enum logic [0:0] {
        FILL,
        REPLAY
    } buf_state_t;

    // Width of a counter or address that spans n values; never narrower than 1 bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mvu_inp_buf_mem.sv
// SF-deep register array holding one input vector for replay.
// One synchronous write port, one combinational read port.
module mvu_inp_buf_mem
    import mvau_defn::*;
#(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 8,
    parameter int unsigned AddrW = 2
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AddrW-1:0] i_waddr,
    input  logic [Width-1:0] i_wdata,
    input  logic [AddrW-1:0] i_raddr,
    output logic [Width-1:0] o_rdata
);

    logic [Width-1:0] r_mem [Depth];

    // Storage write; no reset since every entry is written before it is read.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Combinational read for the replay path.
    always_comb begin
        o_rdata = r_mem[i_raddr];
    end

endmodule

// File: rtl/mvu_inp_buf.sv
// Input-activation buffer ahead of the MVU PE array. Forwards the first pass
// of each vector as it arrives, then replays it NF-1 more times from storage.
module mvu_inp_buf
    import mvau_defn::*;
#(
    parameter int unsigned SF = 4,
    parameter int unsigned NF = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [TI-1:0] in_act,
    input  logic          in_v,
    output logic          in_rdy,
    output logic [TI-1:0] out_act,
    output logic          out_v,
    input  logic          out_rdy,
    output logic          sf_last,
    output logic          buf_busy
);

    localparam int unsigned SfW = cnt_width(SF);
    localparam int unsigned NfW = cnt_width(NF);
    localparam logic [SfW-1:0] SfLast = SfW'(SF - 1);
    localparam logic [NfW-1:0] NfLast = NfW'(NF - 1);

    buf_state_t     r_state;
    buf_state_t     w_state_nxt;
    logic [SfW-1:0] r_sf_cnt;
    logic [SfW-1:0] w_sf_cnt_nxt;
    logic [NfW-1:0] r_nf_cnt;
    logic [NfW-1:0] w_nf_cnt_nxt;
    logic [TI-1:0]  r_out_act;
    logic [TI-1:0]  w_out_act_nxt;
    logic           r_out_v;
    logic           w_out_v_nxt;
    logic           r_sf_last;
    logic           w_sf_last_nxt;

    logic           w_adv;
    logic           w_sf_at_last;
    logic           w_in_rdy;
    logic           w_we;
    logic [TI-1:0]  w_rdata;

    // Output register may load when it is empty or being consumed this cycle.
    assign w_adv        = !r_out_v | out_rdy;
    assign w_sf_at_last = (r_sf_cnt == SfLast);

    mvu_inp_buf_mem #(
        .Depth (SF),
        .Width (TI),
        .AddrW (SfW)
    ) u_mem (
        .i_clk   (clk),
        .i_we    (w_we),
        .i_waddr (r_sf_cnt),
        .i_wdata (in_act),
        .i_raddr (r_sf_cnt),
        .o_rdata (w_rdata)
    );

    // Next-state for FSM, fold counters and output register.
    always_comb begin
        w_state_nxt   = r_state;
        w_sf_cnt_nxt  = r_sf_cnt;
        w_nf_cnt_nxt  = r_nf_cnt;
        w_out_act_nxt = r_out_act;
        w_out_v_nxt   = r_out_v;
        w_sf_last_nxt = r_sf_last;
        w_in_rdy      = 1'b0;
        w_we          = 1'b0;

        unique case (r_state)
            FILL: begin
                w_in_rdy = w_adv;
                if (w_adv) begin
                    if (in_v) begin
                        w_we          = 1'b1;
                        w_out_act_nxt = in_act;
                        w_out_v_nxt   = 1'b1;
                        w_sf_last_nxt = w_sf_at_last;
                        if (w_sf_at_last) begin
                            w_sf_cnt_nxt = '0;
                            // Single-pass configuration never leaves FILL.
                            if (NF > 1) begin
                                w_nf_cnt_nxt = NfW'(1);
                                w_state_nxt  = REPLAY;
                            end
                        end else begin
                            w_sf_cnt_nxt = r_sf_cnt + SfW'(1);
                        end
                    end else begin
                        w_out_v_nxt   = 1'b0;
                        w_sf_last_nxt = 1'b0;
                    end
                end
            end

            REPLAY: begin
                if (w_adv) begin
                    w_out_act_nxt = w_rdata;
                    w_out_v_nxt   = 1'b1;
                    w_sf_last_nxt = w_sf_at_last;
                    if (w_sf_at_last) begin
                        w_sf_cnt_nxt = '0;
                        // Last word of last pass: reopen input so the next vector overlaps.
                        if (r_nf_cnt == NfLast) begin
                            w_nf_cnt_nxt = '0;
                            w_state_nxt  = FILL;
                        end else begin
                            w_nf_cnt_nxt = r_nf_cnt + NfW'(1);
                        end
                    end else begin
                        w_sf_cnt_nxt = r_sf_cnt + SfW'(1);
                    end
                end
            end

            default: begin
                w_state_nxt = FILL;
            end
        endcase
    end

    // State, counters and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= FILL;
            r_sf_cnt  <= '0;
            r_nf_cnt  <= '0;
            r_out_act <= '0;
            r_out_v   <= 1'b0;
            r_sf_last <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_sf_cnt  <= w_sf_cnt_nxt;
            r_nf_cnt  <= w_nf_cnt_nxt;
            r_out_act <= w_out_act_nxt;
            r_out_v   <= w_out_v_nxt;
            r_sf_last <= w_sf_last_nxt;
        end
    end

    assign in_rdy   = w_in_rdy;
    assign out_act  = r_out_act;
    assign out_v    = r_out_v;
    assign sf_last  = r_sf_last;
    assign buf_busy = (r_state == REPLAY);

endmodule
